// File: rtl/one_to_sixteen_deserializer.sv
// one_to_sixteen_deserializer
// Collects a 16-bit MSB-first word on data_in while the active-low frame
// select ss is held low. The word is presented on a held parallel output
// with a valid/ack handshake. Mid-frame aborts and overruns are reported.
// Optional feature macro: DESER_INPUT_SYNC_EN adds 2-flop input
// synchronizers on ss and data_in, which adds two clocks to every latency.
module one_to_sixteen_deserializer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ss,
  input  logic        data_in,
  input  logic        data_ack,
  output logic [15:0] data_output,
  output logic        data_valid,
  output logic        busy,
  output logic        overrun,
  output logic        frame_abort,
  output logic [3:0]  bit_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECV    = 2'b01,
    DONE    = 2'b10,
    HOLDOFF = 2'b11
  } state_t;

  logic ss_i;
  logic din_i;

`ifdef DESER_INPUT_SYNC_EN
  logic [1:0] ss_sync_q;
  logic [1:0] din_sync_q;

  // Two-stage synchronizers; ss idles high so no spurious frame start after reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ss_sync_q  <= 2'b11;
      din_sync_q <= '0;
    end else begin
      ss_sync_q  <= {ss_sync_q[0], ss};
      din_sync_q <= {din_sync_q[0], data_in};
    end
  end

  assign ss_i  = ss_sync_q[1];
  assign din_i = din_sync_q[1];
`else
  assign ss_i  = ss;
  assign din_i = data_in;
`endif

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;

  // Next-state and next-output computation for the receive FSM and handshake
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    abort_d = 1'b0;

    // Consumer ack; a transfer in DONE below overrides valid_d
    if (data_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!ss_i) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (ss_i) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          shift_d = '0;
          state_d = IDLE;
        end else begin
          shift_d = {shift_q[14:0], din_i};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_d = DONE;
        end
      end
      DONE: begin
        if (!valid_q || data_ack) begin
          dout_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        state_d = ss_i ? IDLE : HOLDOFF;
      end
      HOLDOFF: begin
        if (ss_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RECV) || (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
    end
  end

  assign data_output = dout_q;
  assign data_valid  = valid_q;
  assign busy        = busy_q;
  assign overrun     = ovr_q;
  assign frame_abort = abort_q;
  assign bit_count   = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_one_to_sixteen_deserializer.sv
// Directed self-checking bench for one_to_sixteen_deserializer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_one_to_sixteen_deserializer;

`ifdef DESER_INPUT_SYNC_EN
  localparam int unsigned SYNC_DLY = 2;
`else
  localparam int unsigned SYNC_DLY = 0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        ss;
  logic        data_in;
  logic        data_ack;
  logic [15:0] data_output;
  logic        data_valid;
  logic        busy;
  logic        overrun;
  logic        frame_abort;
  logic [3:0]  bit_count;
  logic [1:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic        pre_valid;

  one_to_sixteen_deserializer dut (
    .clock       (clock),
    .resetn      (resetn),
    .ss          (ss),
    .data_in     (data_in),
    .data_ack    (data_ack),
    .data_output (data_output),
    .data_valid  (data_valid),
    .busy        (busy),
    .overrun     (overrun),
    .frame_abort (frame_abort),
    .bit_count   (bit_count),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the DONE edge.
  task automatic send(input logic [15:0] w, input logic ack_on_done, input logic hold_low);
    ss      = 1'b0;
    data_in = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      @(negedge clock);
      data_in  = w[i];
      data_ack = 1'b0;
    end
    @(negedge clock);
    ss      = hold_low ? 1'b0 : 1'b1;
    data_in = 1'b0;
    repeat (SYNC_DLY) @(negedge clock);
    pre_valid = data_valid;
    data_ack  = ack_on_done;
    @(negedge clock);
    data_ack = 1'b0;
  endtask

  task automatic ack_once();
    data_ack = 1'b1;
    @(negedge clock);
    data_ack = 1'b0;
  endtask

  initial begin
    logic [6:0] part;
    part     = 7'b1011001;
    resetn   = 1'b0;
    ss       = 1'b1;
    data_in  = 1'b0;
    data_ack = 1'b0;
    pre_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_dout",  data_output, 16'h0000);
    chk("rst_valid", {15'd0, data_valid}, 16'd0);
    chk("rst_busy",  {15'd0, busy}, 16'd0);
    chk("rst_state", {14'd0, state}, 16'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Single frame
    send(16'hA5C3, 1'b0, 1'b0);
    chk("single_pre_valid", {15'd0, pre_valid}, 16'd0);
    chk("single_valid", {15'd0, data_valid}, 16'd1);
    chk("single_dout",  data_output, 16'hA5C3);
    chk("single_ovr",   {15'd0, overrun}, 16'd0);
    chk("single_busy",  {15'd0, busy}, 16'd0);
    chk("single_state", {14'd0, state}, 16'd0);
    ack_once();
    chk("single_acked", {15'd0, data_valid}, 16'd0);

    // Back-to-back frames, ss high for one cycle between
    send(16'h1234, 1'b0, 1'b0);
    chk("b2b_dout1", data_output, 16'h1234);
    data_ack = 1'b1;
    send(16'hFFFF, 1'b0, 1'b0);
    chk("b2b_dout2",  data_output, 16'hFFFF);
    chk("b2b_valid2", {15'd0, data_valid}, 16'd1);
    chk("b2b_ovr",    {15'd0, overrun}, 16'd0);
    ack_once();
    chk("b2b_acked", {15'd0, data_valid}, 16'd0);

    // Abort after 7 bits
    ss = 1'b0;
    data_in = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      @(negedge clock);
      data_in = part[i];
    end
    @(negedge clock);
    chk("abort_midcount", {12'd0, bit_count}, (SYNC_DLY == 0) ? 16'd7 : 16'd5);
    ss = 1'b1;
    repeat (SYNC_DLY + 1) @(negedge clock);
    chk("abort_pulse", {15'd0, frame_abort}, 16'd1);
    chk("abort_cnt",   {12'd0, bit_count}, 16'd0);
    chk("abort_valid", {15'd0, data_valid}, 16'd0);
    chk("abort_state", {14'd0, state}, 16'd0);
    @(negedge clock);
    chk("abort_pulse_end", {15'd0, frame_abort}, 16'd0);
    send(16'h00F0, 1'b0, 1'b0);
    chk("abort_next_dout",  data_output, 16'h00F0);
    chk("abort_next_valid", {15'd0, data_valid}, 16'd1);
    ack_once();

    // ss held low after the frame parks in HOLDOFF
    send(16'h8001, 1'b0, 1'b1);
    chk("hold_state", {14'd0, state}, 16'd3);
    chk("hold_dout",  data_output, 16'h8001);
    repeat (3) @(negedge clock);
    chk("hold_stays", {14'd0, state}, 16'd3);
    chk("hold_busy",  {15'd0, busy}, 16'd0);
    ss = 1'b1;
    data_ack = 1'b1;
    repeat (SYNC_DLY + 1) @(negedge clock);
    data_ack = 1'b0;
    chk("hold_exit",  {14'd0, state}, 16'd0);
    chk("hold_acked", {15'd0, data_valid}, 16'd0);

    // Overrun
    send(16'hAAAA, 1'b0, 1'b0);
    send(16'h5555, 1'b0, 1'b0);
    chk("ovr_dout",  data_output, 16'hAAAA);
    chk("ovr_flag",  {15'd0, overrun}, 16'd1);
    chk("ovr_valid", {15'd0, data_valid}, 16'd1);
    ack_once();
    chk("ovr_clr_valid", {15'd0, data_valid}, 16'd0);
    chk("ovr_clr_flag",  {15'd0, overrun}, 16'd0);

    // Ack on the DONE edge while a word is held and overrun is set
    send(16'h1111, 1'b0, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    chk("sim_ovr_set", {15'd0, overrun}, 16'd1);
    send(16'h0F0F, 1'b1, 1'b0);
    chk("sim_dout",  data_output, 16'h0F0F);
    chk("sim_valid", {15'd0, data_valid}, 16'd1);
    chk("sim_ovr",   {15'd0, overrun}, 16'd0);

    // Reset at bit 9 with a word still held
    ss = 1'b0;
    data_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      data_in = i[0];
    end
    @(negedge clock);
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_dout",  data_output, 16'h0000);
    chk("mid_rst_valid", {15'd0, data_valid}, 16'd0);
    chk("mid_rst_busy",  {15'd0, busy}, 16'd0);
    chk("mid_rst_cnt",   {12'd0, bit_count}, 16'd0);
    chk("mid_rst_state", {14'd0, state}, 16'd0);
    chk("mid_rst_abort", {15'd0, frame_abort}, 16'd0);
    ss = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("post_rst_abort", {15'd0, frame_abort}, 16'd0);
    send(16'h3C5A, 1'b0, 1'b0);
    chk("post_rst_pre_valid", {15'd0, pre_valid}, 16'd0);
    chk("post_rst_dout",  data_output, 16'h3C5A);
    chk("post_rst_valid", {15'd0, data_valid}, 16'd1);
    chk("post_rst_ovr",   {15'd0, overrun}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, required end within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
